load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-stage load/store unit that sits directly upstream of the word-addressed synchronous data memory. It accepts RV32I load/store requests with byte addresses and funct3 size codes, and checks alignment. Sub-word stores are converted into a read-modify-write of the 32-bit word. Loaded bytes and halfwords are extracted and sign- or zero-extended. A valid/ready handshake stalls the pipeline while a multi-cycle access is in flight.

Parameters:
DATA_WIDTH, 32, word width; fixed at 32 because the byte-lane logic assumes four lanes.
ADDRESS_WIDTH, 16, word-address width of the data memory; byte address is ADDRESS_WIDTH+2 bits.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request; a request transfers when req_valid && req_ready at a rising edge.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW.
req_addr  in  ADDRESS_WIDTH+2  byte address.
req_wdata  in  DATA_WIDTH  store data; low byte or halfword is used for SB/SH.
resp_valid  out  1  one-cycle completion pulse; no backpressure.
resp_data  out  DATA_WIDTH  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned access or illegal funct3; qualified by resp_valid.
mem_a  out  ADDRESS_WIDTH  word address to data memory (byte address bits [ADDRESS_WIDTH+1:2]).
mem_wd  out  DATA_WIDTH  write data to data memory.
mem_we  out  1  write enable to data memory.
mem_rd  in  DATA_WIDTH  memory read data; registered, valid the cycle after mem_a is presented; returns old data on read-during-write.

Behaviour:
- States: IDLE, LOAD, RMW. req_ready = (state == IDLE).
- Reset (rst_n low at an edge):
  - state -> IDLE; resp_valid, resp_err and resp_data -> 0.
  - mem_we is gated to 0 combinationally whenever rst_n = 0.
  - A pending RMW is abandoned and no write occurs.
- IDLE drive:
  - mem_a = req_addr word index; mem_wd = req_wdata.
  - mem_we = req_valid && req_we && funct3 == SW && aligned.
- Error check at acceptance:
  - Errors: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0; load funct3 3/6/7; store funct3 >= 3.
  - On error: no write, state stays IDLE, next cycle resp_valid = 1, resp_err = 1, resp_data = 0.
- SW accepted in cycle N: memory written at the end of cycle N. resp_valid in N+1 with resp_data = 0. Stays IDLE, so it can accept again in N+1.
- Load accepted in cycle N:
  - Memory read is captured at the end of N; state -> LOAD.
  - In N+1, mem_rd is extracted by addr[1:0] and funct3 and registered.
  - resp_valid and resp_data are high in N+2; state -> IDLE, ready in N+2.
- SB/SH accepted in cycle N:
  - Latch word address, byte offset, funct3 and wdata; state -> RMW.
  - In N+1, mem_a = latched address, mem_wd = mem_rd with the target byte/halfword lane replaced, mem_we = 1.
  - resp_valid in N+2; state -> IDLE.
- Lane rules:
  - byte lane k = bits [8k+7:8k], k = addr[1:0].
  - halfword lane = bits [16h+15:16h], h = addr[1].
  - LB/LH sign-extend from the lane MSB; LBU/LHU zero-extend.
- resp_valid is a single-cycle pulse; outside the pulse resp_data and resp_err hold 0.
- Back-to-back requests and a response pulse coinciding with a new acceptance are both legal.

Decomposition:
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum lsu_state_t {IDLE, LOAD, RMW};
  - alignment-check function.
- One combinational sub-module, lsu_align:
  - load extract/extend: mem_rd, offset, funct3 -> data;
  - store merge: old word, wdata, offset, funct3 -> merged word.
  - Instantiated once inside load_store_unit.

Test Plan:
Bench uses a behavioural model of the registered-read memory. Word 0x10 (byte address 0x40) is preloaded with 0x8899AABB.
1. LB 0x41 -> cycle N+2 resp_data 0xFFFFFFAA. LBU 0x43 -> 0x00000088. req_ready low in N+1.
2. LH 0x42 -> 0xFFFF8899. LHU 0x40 -> 0x0000AABB. LW 0x40 -> 0x8899AABB. All have resp_err = 0.
3. SB 0x42 with wdata 0x12345677:
   - mem_we only in N+1, mem_a = 0x10, mem_wd = 0x8877AABB.
   - Following LW 0x40 -> 0x8877AABB.
4. SW 0x44 with 0xDEADBEEF:
   - mem_we in N, resp_valid in N+1.
   - Back-to-back LW 0x44 accepted in N+1 -> 0xDEADBEEF in N+3.
5. Error cases:
   - LW 0x41 -> N+1 resp_err = 1, resp_data = 0, mem_we never high.
   - SH 0x43 -> same.
   - Load with funct3 = 3 -> resp_err = 1.
6. SH 0x40 accepted, rst_n low in N+1:
   - mem_we = 0; word 0x10 unchanged.
   - resp_valid = 0 and req_ready = 1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and the access legality check
package lsu_pkg;
  localparam logic [2:0] F3_B = 3'd0;
  localparam logic [2:0] F3_H = 3'd1;
  localparam logic [2:0] F3_W = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [1:0] {IDLE, LOAD, RMW} lsu_state_t;
  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
    return (f3 == F3_B) || (f3 == F3_H && !off[0]) || (f3 == F3_W && off == 2'b00) ||
           (!we && (f3 == F3_BU || (f3 == F3_HU && !off[0])));
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extract/extend and sub-word store merge into the old word
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] mask, ins;
  assign b = off == 2'd0 ? rd[7:0] : off == 2'd1 ? rd[15:8] : off == 2'd2 ? rd[23:16] : rd[31:24];
  assign h = off[1] ? rd[31:16] : rd[15:0];
  assign ld_data = f3 == F3_B  ? {{24{b[7]}}, b} :
                   f3 == F3_BU ? {24'b0, b} :
                   f3 == F3_H  ? {{16{h[15]}}, h} :
                   f3 == F3_HU ? {16'b0, h} : rd;
  assign mask = f3 == F3_B ? 32'h0000_00ff << {off, 3'b000} :
                f3 == F3_H ? (off[1] ? 32'hffff_0000 : 32'h0000_ffff) : 32'hffff_ffff;
  assign ins = f3 == F3_B ? {4{wdata[7:0]}} : f3 == F3_H ? {2{wdata[15:0]}} : wdata;
  assign st_data = (rd & ~mask) | (ins & mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front end for a word-addressed registered-read memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  output logic                     mem_we,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);
  lsu_state_t state;
  logic [ADDRESS_WIDTH-1:0] lat_a;
  logic [1:0] lat_off;
  logic [2:0] lat_f3;
  logic [DATA_WIDTH-1:0] lat_wd, ld_data, st_data;
  logic ok;
  assign ok = access_ok(req_we, req_funct3, req_addr[1:0]);
  assign req_ready = state == IDLE;
  assign mem_a = state == IDLE ? req_addr[ADDRESS_WIDTH+1:2] : lat_a;
  assign mem_wd = state == RMW ? st_data : req_wdata;
  assign mem_we = rst_n && (state == RMW ||
                  (state == IDLE && req_valid && req_we && req_funct3 == F3_W && ok));
  lsu_align u_align (
    .rd(mem_rd),
    .off(lat_off),
    .f3(lat_f3),
    .wdata(lat_wd),
    .ld_data(ld_data),
    .st_data(st_data)
  );
  // accept requests, sequence load/RMW and emit the one-cycle response pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_data <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_data <= '0;
      case (state)
        IDLE: if (req_valid) begin
          lat_a <= req_addr[ADDRESS_WIDTH+1:2];
          lat_off <= req_addr[1:0];
          lat_f3 <= req_funct3;
          lat_wd <= req_wdata;
          if (!ok) begin
            resp_valid <= 1'b1;
            resp_err <= 1'b1;
          end else if (req_we && req_funct3 == F3_W) resp_valid <= 1'b1;
          else state <= req_we ? RMW : LOAD;
        end
        LOAD: begin
          resp_valid <= 1'b1;
          resp_data <= ld_data;
          state <= IDLE;
        end
        default: begin
          resp_valid <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a registered-read memory model
module tb_load_store_unit;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [17:0] req_addr = 0;
  logic [31:0] req_wdata = 0, resp_data, mem_wd, mem_rd;
  logic req_ready, resp_valid, resp_err, mem_we;
  logic [15:0] mem_a;
  logic [31:0] mem [0:65535];
  int checks = 0, failures = 0, cyc = 0, we_cnt = 0;
  bit run = 0;
  typedef struct {string nm; logic [31:0] d; logic e; int c;} exp_t;
  exp_t sb[$];

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
    mem_rd <= mem[mem_a];
  end
  always @(negedge clk) if (mem_we) we_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (run && rst_n) begin
      if (resp_valid) begin
        if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk({e.nm, "_data"}, resp_data, e.d);
          chk({e.nm, "_err"}, {31'b0, resp_err}, {31'b0, e.e});
          chk({e.nm, "_cycle"}, cyc, e.c);
        end
      end else chk("idle_zero", resp_data | {31'b0, resp_err}, 32'd0);
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [17:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                       input int lat, input bit push, input string nm, output logic we_n);
    int n;
    bit ok = 0;
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (req_ready) ok = 1;
      else @(negedge clk);
    end
    if (!ok) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    we_n = mem_we;
    n = cyc;
    if (push && ok) sb.push_back('{nm, ed, ee, n + lat});
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
  endtask

  initial begin
    logic w;
    int base;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[16'h10] = 32'h8899AABB;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_mem_we", {31'b0, mem_we}, 32'd0);
    run = 1;
    @(negedge clk);
    issue(0, 3'd0, 18'h41, 0, 32'hFFFFFFAA, 0, 2, 1, "lb_41", w);
    #1 chk("lb_ready_n1", {31'b0, req_ready}, 32'd0);
    issue(0, 3'd4, 18'h43, 0, 32'h00000088, 0, 2, 1, "lbu_43", w);
    issue(0, 3'd1, 18'h42, 0, 32'hFFFF8899, 0, 2, 1, "lh_42", w);
    issue(0, 3'd5, 18'h40, 0, 32'h0000AABB, 0, 2, 1, "lhu_40", w);
    issue(0, 3'd2, 18'h40, 0, 32'h8899AABB, 0, 2, 1, "lw_40", w);
    @(negedge clk);
    issue(1, 3'd0, 18'h42, 32'h12345677, 32'h0, 0, 2, 1, "sb_42", w);
    chk("sb_we_in_n", {31'b0, w}, 32'd0);
    #1;
    chk("sb_we_n1", {31'b0, mem_we}, 32'd1);
    chk("sb_addr_n1", {16'b0, mem_a}, 32'h10);
    chk("sb_wd_n1", mem_wd, 32'h8877AABB);
    @(negedge clk);
    #1 chk("sb_we_n2", {31'b0, mem_we}, 32'd0);
    issue(0, 3'd2, 18'h40, 0, 32'h8877AABB, 0, 2, 1, "lw_after_sb", w);
    @(negedge clk);
    issue(1, 3'd2, 18'h44, 32'hDEADBEEF, 32'h0, 0, 1, 1, "sw_44", w);
    chk("sw_we_in_n", {31'b0, w}, 32'd1);
    issue(0, 3'd2, 18'h44, 0, 32'hDEADBEEF, 0, 2, 1, "lw_44_b2b", w);
    @(negedge clk);
    base = we_cnt;
    issue(0, 3'd2, 18'h41, 0, 32'h0, 1, 1, 1, "lw_41_err", w);
    chk("lw_err_we", {31'b0, w}, 32'd0);
    issue(1, 3'd1, 18'h43, 32'hFFFF, 32'h0, 1, 1, 1, "sh_43_err", w);
    chk("sh_err_we", {31'b0, w}, 32'd0);
    issue(0, 3'd3, 18'h40, 0, 32'h0, 1, 1, 1, "ld_f3_3_err", w);
    issue(1, 3'd4, 18'h40, 0, 32'h0, 1, 1, 1, "st_f3_4_err", w);
    @(negedge clk);
    chk("err_no_writes", we_cnt - base, 32'd0);
    issue(1, 3'd1, 18'h40, 32'h0000CAFE, 32'h0, 0, 2, 0, "sh_40_rst", w);
    rst_n = 0;
    #1 chk("rst_gate_we", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_word_kept", mem[16'h10], 32'h8877AABB);
    @(negedge clk);
    issue(0, 3'd2, 18'h40, 0, 32'h8877AABB, 0, 2, 1, "lw_after_rst", w);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
